// File: rtl/soc_addr_map_pkg.sv
// Shared types and register-index helpers for the runtime-programmable SoC address map.
package soc_addr_map_pkg;

    localparam int MapAddrWidth   = 64;
    localparam int RuleWords      = 3;
    localparam int DefaultNrRules = 11;

    typedef struct packed {
        logic nonidem;
        logic cached;
        logic exec;
        logic valid;
    } attr_t;

    typedef struct packed {
        logic [MapAddrWidth-1:0] base;
        logic [MapAddrWidth-1:0] length;
        attr_t                   attr;
    } rule_t;

    typedef enum logic {
        CFG_IDLE,
        CFG_RESP
    } cfg_state_e;

    // Control words sit directly after the rule table, so their indices depend on the rule count.
    function automatic int lock_idx(input int nr_rules);
        return RuleWords * nr_rules;
    endfunction

    localparam int LockIdx     = lock_idx(DefaultNrRules);
    localparam int MissCntIdx  = LockIdx + 1;
    localparam int MissAddrIdx = LockIdx + 2;

endpackage

// File: rtl/soc_addr_map_match.sv
// Combinational priority matcher: the lowest-indexed enabled rule covering the address wins.
module soc_addr_map_match
    import soc_addr_map_pkg::*;
#(
    parameter int NrRules   = 11,
    parameter int AddrWidth = 64,
    parameter int IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  rule_t [NrRules-1:0]  rules,
    input  logic [AddrWidth-1:0] addr,
    output logic                 hit,
    output logic [IdxWidth-1:0]  idx,
    output logic                 exec,
    output logic                 cached,
    output logic                 nonidem
);

    // One extra bit keeps base+length ranges that run past the top of the address space matching.
    function automatic logic covers(input logic [AddrWidth-1:0] a,
                                    input logic [AddrWidth-1:0] b,
                                    input logic [AddrWidth-1:0] l);
        logic [AddrWidth:0] offset;
        offset = {1'b0, a} - {1'b0, b};
        return (l != '0) && ({1'b0, a} >= {1'b0, b}) && (offset < {1'b0, l});
    endfunction

    // Scanning downwards lets lower indices overwrite higher ones on overlap.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        exec    = 1'b0;
        cached  = 1'b0;
        nonidem = 1'b0;
        for (int r = NrRules - 1; r >= 0; r--) begin
            if (rules[r].attr.valid &&
                covers(addr, rules[r].base[AddrWidth-1:0], rules[r].length[AddrWidth-1:0])) begin
                hit     = 1'b1;
                idx     = IdxWidth'(r);
                exec    = rules[r].attr.exec;
                cached  = rules[r].attr.cached;
                nonidem = rules[r].attr.nonidem;
            end
        end
    end

endmodule

// File: rtl/soc_addr_map_ctrl.sv
// Programmable address map: config register file, lock, and one-stage lookup pipeline.
// Optional miss logging is enabled by defining SOC_ADDR_MAP_MISS_LOG_EN.
module soc_addr_map_ctrl
    import soc_addr_map_pkg::*;
#(
    parameter int                                   NrRules   = 11,
    parameter int                                   AddrWidth = 64,
    parameter logic [NrRules-1:0][AddrWidth-1:0]    RstBase   = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0]    RstLength = '0,
    parameter logic [NrRules-1:0][3:0]              RstAttr   = '0,
    parameter int                                   IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [7:0]           cfg_addr_i,
    input  logic [63:0]          cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_rvalid_o,
    output logic [63:0]          cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lkp_valid_i,
    output logic                 lkp_ready_o,
    input  logic [AddrWidth-1:0] lkp_addr_i,
    output logic                 lkp_valid_o,
    input  logic                 lkp_ready_i,
    output logic                 lkp_hit_o,
    output logic [IdxWidth-1:0]  lkp_idx_o,
    output logic                 lkp_exec_o,
    output logic                 lkp_cached_o,
    output logic                 lkp_nonidem_o,
    output logic                 locked_o
);

    localparam logic [7:0] LockAddr = 8'(lock_idx(NrRules));

    rule_t [NrRules-1:0] rules;
    logic                locked;
    cfg_state_e          cfg_state;

    logic [IdxWidth-1:0] rule_idx;
    logic [1:0]          word_sel;
    logic [63:0]         rd_val;
    logic                acc_err;
    logic                tbl_we;
    logic                lock_set;

    logic                m_hit;
    logic [IdxWidth-1:0] m_idx;
    logic                m_exec;
    logic                m_cached;
    logic                m_nonidem;
    logic                lkp_accept;

`ifdef SOC_ADDR_MAP_MISS_LOG_EN
    logic [31:0]          miss_cnt;
    logic [AddrWidth-1:0] miss_addr;
    logic                 cnt_clr;
`endif

    assign cfg_gnt_o   = cfg_req_i;
    assign locked_o    = locked;
    assign lkp_ready_o = !lkp_valid_o || lkp_ready_i;
    assign lkp_accept  = lkp_valid_i && lkp_ready_o;

    soc_addr_map_match #(
        .NrRules   (NrRules),
        .AddrWidth (AddrWidth),
        .IdxWidth  (IdxWidth)
    ) u_match (
        .rules   (rules),
        .addr    (lkp_addr_i),
        .hit     (m_hit),
        .idx     (m_idx),
        .exec    (m_exec),
        .cached  (m_cached),
        .nonidem (m_nonidem)
    );

    // Decode the word index; rd_val always reflects the table before this cycle's write.
    always_comb begin
        rule_idx = IdxWidth'(cfg_addr_i / 8'(RuleWords));
        word_sel = 2'(cfg_addr_i % 8'(RuleWords));
        rd_val   = '0;
        acc_err  = 1'b0;
        tbl_we   = 1'b0;
        lock_set = 1'b0;
`ifdef SOC_ADDR_MAP_MISS_LOG_EN
        cnt_clr  = 1'b0;
`endif
        if (cfg_addr_i < LockAddr) begin
            case (word_sel)
                2'd0:    rd_val = rules[rule_idx].base;
                2'd1:    rd_val = rules[rule_idx].length;
                2'd2:    rd_val = {60'b0, rules[rule_idx].attr};
                default: rd_val = '0;
            endcase
            if (cfg_we_i) begin
                if (locked) acc_err = 1'b1;
                else        tbl_we  = 1'b1;
            end
        end else if (cfg_addr_i == LockAddr) begin
            rd_val = {63'b0, locked};
            // Clearing the lock is silently ignored; only a redundant set while locked is an error.
            if (cfg_we_i && cfg_wdata_i[0]) begin
                if (locked) acc_err  = 1'b1;
                else        lock_set = 1'b1;
            end
`ifdef SOC_ADDR_MAP_MISS_LOG_EN
        end else if (cfg_addr_i == LockAddr + 8'd1) begin
            rd_val  = {32'b0, miss_cnt};
            cnt_clr = cfg_we_i;
        end else if (cfg_addr_i == LockAddr + 8'd2) begin
            rd_val  = 64'(miss_addr);
            acc_err = cfg_we_i;
`endif
        end else begin
            acc_err = 1'b1;
        end
        if (acc_err) rd_val = '0;
    end

    // Config response FSM: every request produces exactly one response on the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_state    <= CFG_IDLE;
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            if (cfg_req_i) begin
                cfg_rdata_o <= rd_val;
                cfg_err_o   <= acc_err;
            end
            case (cfg_state)
                CFG_IDLE: if (cfg_req_i)  cfg_state <= CFG_RESP;
                CFG_RESP: if (!cfg_req_i) cfg_state <= CFG_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NrRules; r++) begin
                rules[r].base   <= MapAddrWidth'(RstBase[r]);
                rules[r].length <= MapAddrWidth'(RstLength[r]);
                rules[r].attr   <= attr_t'(RstAttr[r]);
            end
            locked <= 1'b0;
        end else if (cfg_req_i) begin
            if (tbl_we) begin
                case (word_sel)
                    2'd0:    rules[rule_idx].base   <= MapAddrWidth'(cfg_wdata_i[AddrWidth-1:0]);
                    2'd1:    rules[rule_idx].length <= MapAddrWidth'(cfg_wdata_i[AddrWidth-1:0]);
                    2'd2:    rules[rule_idx].attr   <= attr_t'(cfg_wdata_i[3:0]);
                    default: ;
                endcase
            end
            if (lock_set) locked <= 1'b1;
        end
    end

    // Result register holds while the consumer stalls, so a stalled result stays stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lkp_valid_o   <= 1'b0;
            lkp_hit_o     <= 1'b0;
            lkp_idx_o     <= '0;
            lkp_exec_o    <= 1'b0;
            lkp_cached_o  <= 1'b0;
            lkp_nonidem_o <= 1'b0;
        end else if (lkp_accept) begin
            lkp_valid_o   <= 1'b1;
            lkp_hit_o     <= m_hit;
            lkp_idx_o     <= m_idx;
            lkp_exec_o    <= m_exec;
            lkp_cached_o  <= m_cached;
            lkp_nonidem_o <= m_nonidem;
        end else if (lkp_ready_i) begin
            lkp_valid_o   <= 1'b0;
        end
    end

`ifdef SOC_ADDR_MAP_MISS_LOG_EN
    // A clear from the config port wins over a miss counted in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt  <= '0;
            miss_addr <= '0;
        end else begin
            if (cfg_req_i && cnt_clr) begin
                miss_cnt <= '0;
            end else if (lkp_accept && !m_hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (lkp_accept && !m_hit) miss_addr <= lkp_addr_i;
        end
    end
`endif

endmodule

// File: tb/tb_soc_addr_map_ctrl.sv
// Self-checking bench for soc_addr_map_ctrl: directed steps plus randomized traffic against a table model.
module tb_soc_addr_map_ctrl;

    localparam int NrRules = 11;
    localparam logic [NrRules-1:0][63:0] TbRstBase   = 704'(64'h8000_0000) << 64;
    localparam logic [NrRules-1:0][63:0] TbRstLength = 704'(64'h4000_0000) << 64;
    localparam logic [NrRules-1:0][3:0]  TbRstAttr   = 44'h7 << 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_req, cfg_we;
    logic [7:0]  cfg_addr;
    logic [63:0] cfg_wdata;
    logic        cfg_gnt, cfg_rvalid, cfg_err;
    logic [63:0] cfg_rdata;
    logic        lkp_valid_in, lkp_ready_out, lkp_valid_out, lkp_ready_in;
    logic [63:0] lkp_addr;
    logic        hit, exec, cached, nonidem, locked;
    logic [3:0]  idx;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] m_base [NrRules];
    logic [63:0] m_len  [NrRules];
    logic [3:0]  m_attr [NrRules];
    bit          m_locked;
    logic [31:0] m_miss_cnt;
    logic [63:0] m_miss_addr;
    bit          exp_valid;
    logic [7:0]  exp_res;

    always #5 clk = ~clk;

    soc_addr_map_ctrl #(
        .NrRules   (NrRules),
        .AddrWidth (64),
        .RstBase   (TbRstBase),
        .RstLength (TbRstLength),
        .RstAttr   (TbRstAttr)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_req_i     (cfg_req),
        .cfg_we_i      (cfg_we),
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .cfg_gnt_o     (cfg_gnt),
        .cfg_rvalid_o  (cfg_rvalid),
        .cfg_rdata_o   (cfg_rdata),
        .cfg_err_o     (cfg_err),
        .lkp_valid_i   (lkp_valid_in),
        .lkp_ready_o   (lkp_ready_out),
        .lkp_addr_i    (lkp_addr),
        .lkp_valid_o   (lkp_valid_out),
        .lkp_ready_i   (lkp_ready_in),
        .lkp_hit_o     (hit),
        .lkp_idx_o     (idx),
        .lkp_exec_o    (exec),
        .lkp_cached_o  (cached),
        .lkp_nonidem_o (nonidem),
        .locked_o      (locked)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int r = 0; r < NrRules; r++) begin
            m_base[r] = TbRstBase[r];
            m_len[r]  = TbRstLength[r];
            m_attr[r] = TbRstAttr[r];
        end
        m_locked    = 1'b0;
        m_miss_cnt  = '0;
        m_miss_addr = '0;
        exp_valid   = 1'b0;
        exp_res     = '0;
    endtask

    // Result packed as {hit, idx[3:0], exec, cached, nonidem}; first covering rule in index order wins.
    function automatic logic [7:0] modelLookup(input logic [63:0] a);
        for (int r = 0; r < NrRules; r++) begin
            if (m_attr[r][0] && m_len[r] != 0 && a >= m_base[r] && (a - m_base[r]) < m_len[r])
                return {1'b1, 4'(r), m_attr[r][1], m_attr[r][2], m_attr[r][3]};
        end
        return 8'h00;
    endfunction

    task automatic modelAccess(input bit we, input logic [7:0] a, input logic [63:0] wd,
                               output logic [63:0] rd, output bit err);
        int w_idx = int'(a);
        int r     = w_idx / 3;
        int w     = w_idx % 3;
        rd  = '0;
        err = 1'b0;
        if (w_idx < 3 * NrRules) begin
            if (!we)           rd  = (w == 0) ? m_base[r] : (w == 1) ? m_len[r] : 64'(m_attr[r]);
            else if (m_locked) err = 1'b1;
            else if (w == 0)   m_base[r] = wd;
            else if (w == 1)   m_len[r]  = wd;
            else               m_attr[r] = wd[3:0];
        end else if (w_idx == 3 * NrRules) begin
            if (!we) rd = 64'(m_locked);
            else if (wd[0]) begin
                if (m_locked) err = 1'b1;
                else          m_locked = 1'b1;
            end
`ifdef SOC_ADDR_MAP_MISS_LOG_EN
        end else if (w_idx == 3 * NrRules + 1) begin
            if (!we) rd = 64'(m_miss_cnt);
            else     m_miss_cnt = '0;
        end else if (w_idx == 3 * NrRules + 2) begin
            if (!we) rd  = m_miss_addr;
            else     err = 1'b1;
`endif
        end else begin
            err = 1'b1;
        end
        if (err) rd = '0;
    endtask

    // One clock cycle: drive at the falling edge, predict, then check at the next falling edge.
    task automatic applyStimulus(input bit creq, input bit cwe, input logic [7:0] caddr,
                                 input logic [63:0] cwd, input bit lv, input logic [63:0] la,
                                 input bit lr);
        logic [63:0] erd;
        bit          eerr;
        bit          acc;
        cfg_req      = creq;
        cfg_we       = cwe;
        cfg_addr     = caddr;
        cfg_wdata    = cwd;
        lkp_valid_in = lv;
        lkp_addr     = la;
        lkp_ready_in = lr;
        #1;
        checkOutput("cfg_gnt", 64'(cfg_gnt), 64'(creq));
        checkOutput("lkp_ready", 64'(lkp_ready_out), 64'(!exp_valid || lr));
        acc = lv && (!exp_valid || lr);
        if (acc) begin
            exp_res   = modelLookup(la);
            exp_valid = 1'b1;
            if (!exp_res[7]) begin
                if (m_miss_cnt != 32'hFFFF_FFFF) m_miss_cnt = m_miss_cnt + 32'd1;
                m_miss_addr = la;
            end
        end else if (lr) begin
            exp_valid = 1'b0;
        end
        erd  = '0;
        eerr = 1'b0;
        if (creq) modelAccess(cwe, caddr, cwd, erd, eerr);
        @(negedge clk);
        checkOutput("cfg_rvalid", 64'(cfg_rvalid), 64'(creq));
        if (creq) begin
            checkOutput("cfg_err", 64'(cfg_err), 64'(eerr));
            if (!cwe) checkOutput("cfg_rdata", cfg_rdata, erd);
        end
        checkOutput("lkp_valid", 64'(lkp_valid_out), 64'(exp_valid));
        if (exp_valid) checkOutput("lkp_result", 64'({hit, idx, exec, cached, nonidem}), 64'(exp_res));
        checkOutput("locked", 64'(locked), 64'(m_locked));
    endtask

    task automatic cfgWrite(input logic [7:0] a, input logic [63:0] wd);
        applyStimulus(1'b1, 1'b1, a, wd, 1'b0, 64'h0, 1'b1);
    endtask

    task automatic cfgRead(input logic [7:0] a);
        applyStimulus(1'b1, 1'b0, a, 64'h0, 1'b0, 64'h0, 1'b1);
    endtask

    task automatic lookup(input logic [63:0] a);
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b1, a, 1'b1);
    endtask

    function automatic logic [63:0] lkpObs();
        return 64'({hit, idx, exec, cached, nonidem});
    endfunction

    initial begin
        logic [63:0] ra;
        int          r;
        rst_n        = 1'b0;
        cfg_req      = 1'b0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_wdata    = '0;
        lkp_valid_in = 1'b0;
        lkp_addr     = '0;
        lkp_ready_in = 1'b1;
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("rst_rvalid", 64'(cfg_rvalid), 64'h0);
        checkOutput("rst_rdata", cfg_rdata, 64'h0);
        checkOutput("rst_err", 64'(cfg_err), 64'h0);
        checkOutput("rst_lkp_valid", 64'(lkp_valid_out), 64'h0);
        checkOutput("rst_lkp_result", lkpObs(), 64'h0);
        checkOutput("rst_locked", 64'(locked), 64'h0);
        rst_n = 1'b1;

        // Reset-loaded rule 1
        lookup(64'h8000_1000);
        checkOutput("tp1_hit", lkpObs(), 64'h8E);
        lookup(64'hC000_0000);
        checkOutput("tp1_miss", lkpObs(), 64'h00);

        // Program rule 2 and read it back
        cfgWrite(8'd6, 64'h5000_0000);
        cfgWrite(8'd7, 64'h1000);
        cfgWrite(8'd8, 64'hFFFF_FFFF_FFFF_FFF1);
        for (int w = 6; w <= 8; w++) cfgRead(8'(w));
        checkOutput("tp2_attr_rd", cfg_rdata, 64'h1);
        lookup(64'h5000_0FFF);
        checkOutput("tp2_hit", lkpObs(), 64'h90);
        lookup(64'h5000_1000);
        checkOutput("tp2_miss", lkpObs(), 64'h00);

        // Overlapping rules 3 and 5
        cfgWrite(8'd9,  64'h1000_0000);
        cfgWrite(8'd10, 64'h1000);
        cfgWrite(8'd11, 64'h3);
        cfgWrite(8'd15, 64'h0F00_0000);
        cfgWrite(8'd16, 64'h0200_0000);
        cfgWrite(8'd17, 64'h9);
        lookup(64'h1000_0000);
        checkOutput("tp3_low_wins", lkpObs(), 64'h9C);
        cfgWrite(8'd11, 64'h0);
        lookup(64'h1000_0000);
        checkOutput("tp3_disabled", lkpObs(), 64'hA9);

        // Rule 4 running past the top of the address space
        cfgWrite(8'd12, 64'hFFFF_FFFF_FFFF_F000);
        cfgWrite(8'd13, 64'h2000);
        cfgWrite(8'd14, 64'h1);
        lookup(64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("wrap_hit", lkpObs(), 64'hA0);
        lookup(64'hFFFF_FFFF_FFFF_EFFF);

        // Write and lookup in the same cycle: lookup sees the old rule 6
        cfgWrite(8'd18, 64'h7000_0000);
        cfgWrite(8'd19, 64'h100);
        cfgWrite(8'd20, 64'h1);
        applyStimulus(1'b1, 1'b1, 8'd18, 64'h7100_0000, 1'b1, 64'h7000_0010, 1'b1);
        checkOutput("same_cycle_old", lkpObs(), 64'hB0);
        lookup(64'h7000_0010);
        lookup(64'h7100_0010);
        checkOutput("same_cycle_new", lkpObs(), 64'hB0);

        // Backpressure: accept, stall three cycles, then stream
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b1, 64'h8000_2000, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b1, 64'h5000_0010, 1'b0);
        checkOutput("stall_ready", 64'(lkp_ready_out), 64'h0);
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b1, 64'h5000_0010, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b1, 64'h1000_0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b1, 64'h9000_0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b0, 64'h0, 1'b1);

        // Randomized traffic: rules 7..10 reprogrammed, reads anywhere, random flow control
        for (int n = 0; n < 300; n++) begin
            bit          creq, cwe, lv, lr;
            logic [7:0]  caddr;
            logic [63:0] cwd;
            creq = ($urandom_range(0, 3) == 0);
            cwe  = creq && $urandom_range(0, 1) == 1;
            if (cwe) begin
                caddr = 8'($urandom_range(21, 32));
                case (caddr % 3)
                    0:       cwd = 64'($urandom_range(0, 32'h3FFF_FFFF));
                    1:       cwd = 64'($urandom_range(0, 32'h1_0000));
                    default: cwd = 64'($urandom);
                endcase
            end else begin
                caddr = 8'($urandom_range(0, 40));
                cwd   = 64'h0;
            end
            r  = $urandom_range(0, NrRules - 1);
            case ($urandom_range(0, 3))
                0:       ra = m_base[r];
                1:       ra = m_base[r] + m_len[r] - 64'd1;
                2:       ra = m_base[r] + m_len[r];
                default: ra = 64'($urandom);
            endcase
            lv = ($urandom_range(0, 3) != 0);
            lr = ($urandom_range(0, 3) != 0);
            applyStimulus(creq, cwe, caddr, cwd, lv, ra, lr);
        end
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b0, 64'h0, 1'b1);

        // Miss logging
        cfgWrite(8'd34, 64'h1234);
        for (int m = 0; m < 4; m++) lookup(64'h1_0000_0000 + 64'(m));
        lookup(64'hDEAD_0000);
        cfgRead(8'd34);
`ifdef SOC_ADDR_MAP_MISS_LOG_EN
        checkOutput("miss_cnt_val", cfg_rdata, 64'd5);
`else
        checkOutput("miss_cnt_err", 64'(cfg_err), 64'h1);
`endif
        cfgRead(8'd35);
`ifdef SOC_ADDR_MAP_MISS_LOG_EN
        checkOutput("miss_addr_val", cfg_rdata, 64'hDEAD_0000);
`endif
        cfgWrite(8'd35, 64'h0);
        cfgWrite(8'd34, 64'h0);
        cfgRead(8'd34);

        // Lock the table
        cfgWrite(8'd33, 64'h1);
        checkOutput("lock_set", 64'(locked), 64'h1);
        cfgWrite(8'd0, 64'hABCD);
        checkOutput("locked_write_err", 64'(cfg_err), 64'h1);
        cfgRead(8'd0);
        cfgWrite(8'd33, 64'h0);
        cfgWrite(8'd33, 64'h1);
        cfgRead(8'd33);
        cfgRead(8'd200);
        lookup(64'h2_0000_0000);
        cfgRead(8'd34);

        // Reset while a cfg response and a lookup result are in flight
        cfg_req      = 1'b1;
        cfg_we       = 1'b0;
        cfg_addr     = 8'd3;
        lkp_valid_in = 1'b1;
        lkp_addr     = 64'h8000_1000;
        lkp_ready_in = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_rvalid", 64'(cfg_rvalid), 64'h0);
        checkOutput("midrst_lkp_valid", 64'(lkp_valid_out), 64'h0);
        checkOutput("midrst_locked", 64'(locked), 64'h0);
        cfg_req      = 1'b0;
        lkp_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 1'b0, 64'h0, 1'b1);
        lookup(64'h8000_1000);
        cfgRead(8'd3);
        cfgRead(8'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
